// File: rtl/neureka_tcdm_responder_if.sv
// Bundle of MP parallel 32-bit TCDM ports between initiators and the memory-side responder.
// Handshake: a port transfers when req & gnt; an initiator holds req/add/wen/be/data until gnt.
interface neureka_tcdm_responder_if #(
  parameter int MP = 8
);
  logic [MP-1:0]        req;
  logic [MP-1:0]        gnt;
  logic [MP-1:0][31:0]  add;
  logic [MP-1:0]        wen;
  logic [MP-1:0][3:0]   be;
  logic [MP-1:0][31:0]  data;
  logic [MP-1:0][31:0]  r_data;
  logic [MP-1:0]        r_valid;

  modport master (
    output req, add, wen, be, data,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, be, data,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/neureka_tcdm_responder.sv
// Memory-side TCDM responder: same-cycle grant, one-cycle read latency from a shared
// word array, plus sticky error flag and read/write counters.
module neureka_tcdm_responder #(
  parameter int          MP        = 8,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [MP-1:0]           stall_i,
  neureka_tcdm_responder_if.slave tcdm,
  output logic                    err_o,
  output logic [31:0]             rd_cnt_o,
  output logic [31:0]             wr_cnt_o
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic [MP-1:0]          fire;
  logic [MP-1:0]          rd_fire;
  logic [MP-1:0]          wr_fire;
  logic [MP-1:0]          ok;
  logic [MP-1:0][31:0]    off;
  logic [MP-1:0][AW-1:0]  idx;

  logic [31:0] mem [DEPTH];

  assign tcdm.gnt = tcdm.req & ~stall_i;

  always_comb begin
    fire    = tcdm.req & ~stall_i;
    rd_fire = fire & tcdm.wen;
    wr_fire = fire & ~tcdm.wen;
    off     = '0;
    ok      = '0;
    idx     = '0;
    for (int i = 0; i < MP; i++) begin
      off[i] = tcdm.add[i] - BASE_ADDR;
      ok[i]  = (off[i][1:0] == 2'b00) && (off[i][31:2] < DEPTH_W);
      idx[i] = off[i][AW+1:2];
    end
  end

  // Ports are applied in ascending order so the highest port wins each contended byte.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MP; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_fire[i] && ok[i] && tcdm.be[i][k]) begin
          mem[idx[i]][8*k +: 8] <= tcdm.data[i][8*k +: 8];
        end
      end
    end
  end

  // Reads sample the array before this edge's writes land, giving old data on conflicts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcdm.r_valid <= '0;
      tcdm.r_data  <= '0;
      err_o        <= 1'b0;
      rd_cnt_o     <= '0;
      wr_cnt_o     <= '0;
    end else begin
      tcdm.r_valid <= rd_fire;
      for (int i = 0; i < MP; i++) begin
        if (rd_fire[i]) begin
          tcdm.r_data[i] <= ok[i] ? mem[idx[i]] : ERR_DATA;
        end
      end
      err_o    <= err_o | (|(fire & ~ok));
      rd_cnt_o <= rd_cnt_o + 32'($countones(rd_fire));
      wr_cnt_o <= wr_cnt_o + 32'($countones(wr_fire));
    end
  end
endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic, all compared each cycle against a word-array reference model.
module tb_neureka_tcdm_responder;
  localparam int          MP    = 8;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;
  localparam int          W     = 35;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [MP-1:0]     stall;
  logic              err;
  logic [31:0]       rd_cnt;
  logic [31:0]       wr_cnt;

  neureka_tcdm_responder_if #(.MP(MP)) bus ();

  neureka_tcdm_responder #(.MP(MP), .DEPTH(DEPTH), .BASE_ADDR(BASE), .ERR_DATA(ERRD)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .stall_i  (stall),
    .tcdm     (bus),
    .err_o    (err),
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model
  logic [31:0]   m_mem [DEPTH];
  logic [MP-1:0] e_rv  = '0;
  logic [31:0]   e_rd [MP];
  logic          e_err = 1'b0;
  logic [31:0]   e_rc  = '0;
  logic [31:0]   e_wc  = '0;
  logic [W-1:0]  exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a, output int w);
    logic [31:0] off;
    off = a - BASE;
    w   = int'(off >> 2);
    return (off % 4 == 0) && (off / 4 < DEPTH);
  endfunction

  initial begin
    for (int i = 0; i < MP; i++) e_rd[i] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e_rv = '0; e_err = 1'b0; e_rc = '0; e_wc = '0;
        for (int i = 0; i < MP; i++) e_rd[i] = '0;
        exp_q.delete();
      end else begin
        int  w;
        bit  ok;
        e_rv = '0;
        for (int i = 0; i < MP; i++) begin
          if (bus.req[i] && !stall[i]) begin
            ok = addr_ok(bus.add[i], w);
            if (!ok) e_err = 1'b1;
            if (bus.wen[i]) begin
              e_rv[i] = 1'b1;
              e_rd[i] = ok ? m_mem[w] : ERRD;
              e_rc++;
              exp_q.push_back({3'(i), e_rd[i]});
            end else begin
              e_wc++;
            end
          end
        end
        for (int i = 0; i < MP; i++) begin
          if (bus.req[i] && !stall[i] && !bus.wen[i] && addr_ok(bus.add[i], w)) begin
            for (int k = 0; k < 4; k++)
              if (bus.be[i][k]) m_mem[w][8*k +: 8] = bus.data[i][8*k +: 8];
          end
        end
      end
    end
  end

  // scoreboard compare on the falling edge
  initial begin
    logic [W-1:0] q;
    forever begin
      @(negedge clk);
      chk("gnt", 32'(bus.gnt), 32'(bus.req & ~stall));
      chk("r_valid", 32'(bus.r_valid), 32'(e_rv));
      chk("err", 32'(err), 32'(e_err));
      chk("rd_cnt", rd_cnt, e_rc);
      chk("wr_cnt", wr_cnt, e_wc);
      for (int i = 0; i < MP; i++) begin
        if (e_rv[i]) begin
          if (exp_q.size() == 0) begin
            chk("rsp_queue_empty", 32'd0, 32'd1);
          end else begin
            q = exp_q.pop_front();
            chk("rsp_port", 32'(q[34:32]), 32'(i));
            chk("r_data", bus.r_data[i], q[31:0]);
          end
        end else begin
          chk("r_data_hold", bus.r_data[i], e_rd[i]);
        end
      end
    end
  end

  // driver tasks
  task automatic idle();
    bus.req = '0; bus.wen = '0; bus.add = '0; bus.be = '0; bus.data = '0; stall = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic next();
    step();
    idle();
  endtask

  task automatic put(input int p, input bit rd, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    bus.req[p] = 1'b1; bus.wen[p] = rd; bus.add[p] = a; bus.be[p] = b; bus.data[p] = d;
  endtask

  initial begin
    logic [31:0]   w0;
    logic [MP-1:0] held;
    int            r;
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
    chk("rst_r_data0", bus.r_data[0], 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_cnt", rd_cnt, 32'd0);
    chk("rst_wr_cnt", wr_cnt, 32'd0);

    // write then read back on port 0
    next(); put(0, 1'b0, BASE + 32'h10, 4'hF, 32'hA5A5_1234);
    next(); put(0, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    next();
    @(negedge clk);
    chk("wr_rd_valid", 32'(bus.r_valid[0]), 32'd1);
    chk("wr_rd_data", bus.r_data[0], 32'hA5A5_1234);
    chk("wr_rd_wr_cnt", wr_cnt, 32'd1);
    chk("wr_rd_rd_cnt", rd_cnt, 32'd1);

    // preload the full array so every later read has defined data
    for (int c = 0; c < DEPTH / MP; c++) begin
      next();
      for (int p = 0; p < MP; p++) put(p, 1'b0, BASE + 32'(4 * (c * MP + p)), 4'hF, $urandom);
    end

    // all ports read at once
    next(); for (int i = 0; i < MP; i++) put(i, 1'b0, BASE + 32'h40 + 32'(4 * i), 4'hF, 32'(i + 1));
    next(); for (int i = 0; i < MP; i++) put(i, 1'b1, BASE + 32'h40 + 32'(4 * i), 4'h0, 32'h0);
    next();
    @(negedge clk);
    chk("wide_valid", 32'(bus.r_valid), 32'hFF);
    for (int i = 0; i < MP; i++) chk("wide_data", bus.r_data[i], 32'(i + 1));

    // byte-enable conflict between ports 2 and 5
    next(); put(0, 1'b0, BASE + 32'h80, 4'hF, 32'h0);
    next(); put(2, 1'b0, BASE + 32'h80, 4'h3, 32'h1111_1111);
            put(5, 1'b0, BASE + 32'h80, 4'h6, 32'h2222_2222);
    next(); put(0, 1'b1, BASE + 32'h80, 4'h0, 32'h0);
    next();
    @(negedge clk);
    chk("conflict_data", bus.r_data[0], 32'h0022_2211);

    // stalled read on port 3 while port 1 streams reads
    next(); stall[3] = 1'b1;
    put(3, 1'b1, BASE + 32'd200, 4'h0, 32'h0);
    put(1, 1'b1, BASE + 32'd204, 4'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("stall_gnt", 32'(bus.gnt[3]), 32'd0);
      chk("stall_rv", 32'(bus.r_valid[3]), 32'd0);
      if (c > 0) chk("stall_other_rv", 32'(bus.r_valid[1]), 32'd1);
      step();
    end
    stall[3] = 1'b0;
    @(negedge clk);
    chk("release_gnt", 32'(bus.gnt[3]), 32'd1);
    next();
    @(negedge clk);
    chk("release_rv", 32'(bus.r_valid[3]), 32'd1);
    chk("release_data", bus.r_data[3], m_mem[50]);

    // out-of-range read and misaligned write
    chk("pre_err", 32'(err), 32'd0);
    w0 = m_mem[0];
    next(); put(0, 1'b1, BASE + 32'(DEPTH * 4), 4'h0, 32'h0);
            put(1, 1'b0, BASE + 32'h2, 4'hF, 32'h1234_5678);
    next();
    @(negedge clk);
    chk("err_rv", 32'(bus.r_valid[0]), 32'd1);
    chk("err_data", bus.r_data[0], 32'hDEAD_BEEF);
    chk("err_set", 32'(err), 32'd1);
    next(); put(0, 1'b1, BASE, 4'h0, 32'h0);
    next();
    @(negedge clk);
    chk("err_storage", bus.r_data[0], w0);
    repeat (3) next();
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);

    // randomized traffic; ungranted requests are held stable
    for (int n = 0; n < 2000; n++) begin
      held = bus.req & stall;
      step();
      for (int p = 0; p < MP; p++) begin
        stall[p] = ($urandom_range(0, 3) == 0);
        if (!held[p]) begin
          bus.req[p]  = $urandom_range(0, 1) == 1;
          bus.wen[p]  = $urandom_range(0, 1) == 1;
          bus.be[p]   = 4'($urandom_range(0, 15));
          bus.data[p] = $urandom;
          r = $urandom_range(0, 15);
          case (r)
            0:       bus.add[p] = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 7));
            1:       bus.add[p] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            2:       bus.add[p] = BASE - 32'd4;
            default: bus.add[p] = BASE + 32'(4 * $urandom_range(0, 63));
          endcase
        end
      end
    end
    next(); next();

    // reset in the cycle after a granted read
    put(2, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    step(); idle();
    rst_n = 1'b0;
    #1;
    chk("rstmid_rv", 32'(bus.r_valid), 32'd0);
    chk("rstmid_rd_cnt", rd_cnt, 32'd0);
    chk("rstmid_wr_cnt", wr_cnt, 32'd0);
    chk("rstmid_err", 32'(err), 32'd0);
    step();
    rst_n = 1'b1;
    next(); put(2, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    next();
    @(negedge clk);
    chk("rstmid_keep", bus.r_data[2], m_mem[4]);
    chk("rstmid_rd_cnt1", rd_cnt, 32'd1);

    next();
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
